// File: rtl/wbuffer_pkg.sv
// wbuffer_pkg -- shared definitions for the window-buffer read controller.
//
// Contents:
//   MODE_*   : window buffer operation codes driven on wbuffer_ctrl.mode
//   SRC_*    : read source codes driven on wbuffer_ctrl.rd_src
//   state_t  : controller FSM state encoding
package wbuffer_pkg;

    localparam logic [2:0] MODE_IDLE  = 3'b000;
    localparam logic [2:0] MODE_W1    = 3'b001;
    localparam logic [2:0] MODE_W2    = 3'b010;
    localparam logic [2:0] MODE_W3    = 3'b011;
    localparam logic [2:0] MODE_W4    = 3'b100;
    localparam logic [2:0] MODE_SHIFT = 3'b101;

    // Top row of a window lives in SRAM, bottom row in SDRAM.
    localparam logic SRC_SRAM  = 1'b0;
    localparam logic SRC_SDRAM = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD1   = 3'd1,
        LD2   = 3'd2,
        LD3   = 3'd3,
        LD4   = 3'd4,
        EMIT  = 3'd5,
        SHIFT = 3'd6,
        DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/wbuffer_ctrl.sv
// wbuffer_ctrl -- walks a 2x2 window over an IMG_W x IMG_H image in raster
// order, issuing the pixel reads that fill an external window buffer.
// The first window of each row loads all four pixels; every following window
// shifts the buffer left and reloads only the right column.
//
// Optional feature: define WBCTRL_STATS_EN to add the win_count output, a
// saturating count of accepted windows cleared on reset and on start.
//
// Ports:
//   clk, nrst          clock (rising edge), asynchronous active-low reset
//   start              begin one frame; ignored while busy
//   rd_req/rd_src/rd_addr  read request, source (0 SRAM, 1 SDRAM), address
//   rd_ack             read data valid this cycle
//   enable_CU, mode    window buffer strobe and operation code
//   win_valid/win_ready    window handshake
//   busy, done         traversal in progress, end-of-frame pulse
//   dbg_state          current FSM state (state_t encoding)
//   win_count          accepted window count (WBCTRL_STATS_EN only)
//
// Handshakes: a read is outstanding while rd_req=1 and completes on the cycle
// rd_ack=1; rd_src/rd_addr hold until then. A window is offered while
// win_valid=1 and is accepted on the cycle win_ready=1; win_valid holds until
// then.
module wbuffer_ctrl
    import wbuffer_pkg::*;
#(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 3,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    output logic              rd_req,
    output logic              rd_src,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    output logic              enable_CU,
    output logic [2:0]        mode,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
`ifdef WBCTRL_STATS_EN
    ,
    output logic [15:0]       win_count
`endif
);

    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 2);

    state_t            state;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row_base;   // row * IMG_W, kept incrementally
    logic              in_load;

    assign in_load   = (state == LD1) || (state == LD2) ||
                       (state == LD3) || (state == LD4);
    assign dbg_state = state;

    // The buffer captures read data on the same edge as rd_ack, so the strobe
    // follows rd_ack combinationally while a load state is active.
    assign enable_CU = (in_load && rd_ack) || (state == SHIFT);

    always_comb begin
        mode = MODE_IDLE;
        case (state)
            LD1:     mode = MODE_W1;
            LD2:     mode = MODE_W2;
            LD3:     mode = MODE_W3;
            LD4:     mode = MODE_W4;
            SHIFT:   mode = MODE_SHIFT;
            default: mode = MODE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            row_base  <= '0;
            rd_req    <= 1'b0;
            rd_src    <= SRC_SRAM;
            rd_addr   <= '0;
            win_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LD1;
                        row      <= '0;
                        col      <= '0;
                        row_base <= '0;
                        busy     <= 1'b1;
                        rd_req   <= 1'b1;
                        rd_src   <= SRC_SRAM;
                        rd_addr  <= '0;
                    end
                end
                LD1: begin
                    if (rd_ack) begin
                        state   <= LD2;
                        rd_addr <= rd_addr + ONE;
                    end
                end
                LD2: begin
                    if (rd_ack) begin
                        rd_src <= SRC_SDRAM;
                        // col is 0 only on the first window of a row, which
                        // needs the full bottom row; after a shift only the
                        // bottom-right pixel is new.
                        if (col == '0) begin
                            state   <= LD3;
                            rd_addr <= row_base + ROW_STEP + col;
                        end else begin
                            state   <= LD4;
                            rd_addr <= row_base + ROW_STEP + col + ONE;
                        end
                    end
                end
                LD3: begin
                    if (rd_ack) begin
                        state   <= LD4;
                        rd_addr <= rd_addr + ONE;
                    end
                end
                LD4: begin
                    if (rd_ack) begin
                        state     <= EMIT;
                        rd_req    <= 1'b0;
                        win_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (col < LAST_COL) begin
                            state <= SHIFT;
                            col   <= col + ONE;
                        end else if (row < LAST_ROW) begin
                            state    <= LD1;
                            row      <= row + ONE;
                            col      <= '0;
                            row_base <= row_base + ROW_STEP;
                            rd_req   <= 1'b1;
                            rd_src   <= SRC_SRAM;
                            rd_addr  <= row_base + ROW_STEP;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // col already points at the new window's left column.
                    state   <= LD2;
                    rd_req  <= 1'b1;
                    rd_src  <= SRC_SRAM;
                    rd_addr <= row_base + col + ONE;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WBCTRL_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            win_count <= '0;
        end else if ((state == IDLE) && start) begin
            win_count <= '0;
        end else if ((state == EMIT) && win_ready && (win_count != 16'hFFFF)) begin
            win_count <= win_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wbuffer_ctrl.sv
module tb_wbuffer_ctrl;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 16;
  localparam int EW     = 2 + 3 + 1 + ADDR_W;

  localparam int K_RD  = 0;
  localparam int K_WIN = 1;
  localparam int K_DONE = 2;

  // clock / reset
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic rd_ack = 1'b0;
  logic win_ready = 1'b0;
  logic rd_req, rd_src, enable_CU, win_valid, busy, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0] mode, dbg_state;
`ifdef WBCTRL_STATS_EN
  logic [15:0] win_count;
`endif

  wbuffer_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .rd_req(rd_req), .rd_src(rd_src), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .enable_CU(enable_CU), .mode(mode),
    .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
`ifdef WBCTRL_STATS_EN
    , .win_count(win_count)
`endif
  );

  int n_tests = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  bit mon_en = 1'b0;
  bit rand_en = 1'b0;
  bit start_pend = 1'b0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ev(input int kind, input int m, input int src, input int addr);
    return {2'(kind), 3'(m), 1'(src), ADDR_W'(addr)};
  endfunction

  function automatic int pix(input int r, input int c);
    return r * IMG_W + c;
  endfunction

  // reference model: the event stream one frame should produce
  task automatic push_frame();
    for (int r = 0; r < IMG_H - 1; r++) begin
      for (int c = 0; c < IMG_W - 1; c++) begin
        if (c == 0) begin
          exp_q.push_back(ev(K_RD, 1, 0, pix(r, c)));
          exp_q.push_back(ev(K_RD, 2, 0, pix(r, c + 1)));
          exp_q.push_back(ev(K_RD, 3, 1, pix(r + 1, c)));
          exp_q.push_back(ev(K_RD, 4, 1, pix(r + 1, c + 1)));
        end else begin
          exp_q.push_back(ev(K_RD, 5, 0, 0));
          exp_q.push_back(ev(K_RD, 2, 0, pix(r, c + 1)));
          exp_q.push_back(ev(K_RD, 4, 1, pix(r + 1, c + 1)));
        end
        exp_q.push_back(ev(K_WIN, 0, 0, 0));
      end
    end
    exp_q.push_back(ev(K_DONE, 0, 0, 0));
  endtask

  // scoreboard monitor
  task automatic sb_pop(input string name, input logic [EW-1:0] got);
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected event %0h, expected none", name, got);
    end else begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, got, e, $time);
      end
    end
  endtask

  logic              prev_rd_wait = 1'b0;
  logic              prev_win_wait = 1'b0;
  logic              prev_done = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              prev_src = 1'b0;
  logic [2:0]        prev_mode = '0;

  always @(negedge clk) begin
    if (mon_en && nrst) begin
      if (enable_CU) begin
        if (mode == 3'b101) sb_pop("shift_event", ev(K_RD, 5, 0, 0));
        else sb_pop("read_event", ev(K_RD, int'(mode), int'(rd_src), int'(rd_addr)));
      end
      if (win_valid && win_ready) sb_pop("window_event", ev(K_WIN, 0, 0, 0));
      if (done) begin
        sb_pop("done_event", ev(K_DONE, 0, 0, 0));
        done_cnt++;
        check("busy_during_done", busy, 1);
      end
      if (prev_done) check("busy_after_done", busy, 0);
      if (prev_rd_wait) begin
        check("rd_req_held", rd_req, 1);
        check("rd_addr_held", rd_addr, prev_addr);
        check("rd_src_held", rd_src, prev_src);
        check("rd_mode_held", mode, prev_mode);
      end
      if (prev_win_wait) check("win_valid_held", win_valid, 1);
      if (win_valid) begin
        check("emit_mode_idle", mode, 0);
        check("emit_enable_low", enable_CU, 0);
      end
      prev_rd_wait  = rd_req && !rd_ack;
      prev_win_wait = win_valid && !win_ready;
      prev_done     = done;
      prev_addr     = rd_addr;
      prev_src      = rd_src;
      prev_mode     = mode;
    end
  end

  // random driver: acks, ready, and stray starts while busy
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) begin
        rd_ack    = ($urandom_range(0, 2) != 0);
        win_ready = ($urandom_range(0, 2) != 0);
        if (busy) begin
          start = ($urandom_range(0, 5) == 0);
        end else begin
          start = start_pend;
          start_pend = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_req"}, rd_req, 0);
    check({tag, "_rd_src"}, rd_src, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_enable_CU"}, enable_CU, 0);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
`ifdef WBCTRL_STATS_EN
    check({tag, "_win_count"}, win_count, 0);
`endif
  endtask

  task automatic wait_idle(input string name, input int max);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < max) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, (k < max) ? 1 : 0, 1);
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_done_count"}, done_cnt, 1);
`ifdef WBCTRL_STATS_EN
    check({name, "_win_count"}, win_count, (IMG_W - 1) * (IMG_H - 1));
`endif
    exp_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    step();
    step();
    nrst = 1'b1;
    step();
    check_all_zero("post_reset_idle");

    // reset in the middle of LD3 with rd_ack held low
    rd_ack = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rd_ack = 1'b0;
    step();
    step();
    check("ld3_reached_mode", mode, 3);
    check("ld3_reached_req", rd_req, 1);
    nrst = 1'b0;
    #1;
    check_all_zero("mid_ld3_reset");
    step();
    nrst = 1'b1;
    step();
    check("wait_for_start_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("restart_mode", mode, 1);
    check("restart_req", rd_req, 1);
    check("restart_src", rd_src, 0);
    check("restart_addr", rd_addr, 0);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    step();

    // full frame, rd_ack and win_ready always high
    mon_en = 1'b1;
    rd_ack = 1'b1;
    win_ready = 1'b1;
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("frame_fast", 500);

    // delayed ack in LD2 and stalled win_ready in EMIT
    rd_ack = 1'b0;
    win_ready = 1'b0;
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    rd_ack = 1'b1;
    #1;
    check("ld1_strobe", enable_CU, 1);
    step();
    rd_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ld2_wait_req", rd_req, 1);
      check("ld2_wait_addr", rd_addr, 1);
      check("ld2_wait_src", rd_src, 0);
      check("ld2_wait_enable", enable_CU, 0);
      step();
    end
    rd_ack = 1'b1;
    #1;
    check("ld2_ack_req", rd_req, 1);
    check("ld2_ack_addr", rd_addr, 1);
    check("ld2_ack_enable", enable_CU, 1);
    step();
    step();
    step();
    rd_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("emit_stall_valid", win_valid, 1);
      check("emit_stall_enable", enable_CU, 0);
      check("emit_stall_mode", mode, 0);
      step();
    end
    win_ready = 1'b1;
    #1;
    check("emit_sixth_valid", win_valid, 1);
    step();
    rd_ack = 1'b1;
    wait_idle("frame_stall", 500);

    // randomized frames with stray starts while busy
    rand_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      push_frame();
      start_pend = 1'b1;
      wait_idle("frame_rand", 3000);
    end
    rand_en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
